// File: rtl/fm_pkg.sv
// Shared types for the pipeline fault monitor: escalation state encoding.
package fm_pkg;

    localparam int FM_ST_W = 2;

    typedef enum logic [FM_ST_W-1:0] {
        FM_OK       = 2'd0,
        FM_DEGRADED = 2'd1,
        FM_FAULT    = 2'd2
    } fm_state_t;

endpackage

// File: rtl/fm_sat_counter.sv
// Saturating up/down event counter; clear has priority but keeps a same-cycle increment.
module fm_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat;

    assign sat = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_ONE : '0;
        end else if (inc_i) begin
            if (!sat) cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/pipeline_fault_monitor.sv
// Error aggregator: sticky flags, saturating counters, OK/DEGRADED/FAULT escalation.
// Optional decay of non-fatal counters is built when FAULT_DECAY_EN is defined.
module pipeline_fault_monitor
    import fm_pkg::*;
#(
    parameter int                NUM_CH       = 6,
    parameter int                CNT_W        = 8,
    parameter logic [NUM_CH-1:0] FATAL_MASK   = NUM_CH'(6'b101010),
    parameter int                DEG_THRESH   = 4,
    parameter int                FLT_THRESH   = 16,
    parameter int                DECAY_PERIOD = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH-1:0]                         err_in,
    input  logic                                      clr_req,
    output logic                                      clr_ack,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    output logic [CNT_W-1:0]                          rd_count,
    output logic [NUM_CH-1:0]                         sticky,
    output logic [FM_ST_W-1:0]                        state,
    output logic                                      stall_req,
    output logic                                      irq
);

    localparam int               RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEG_T = CNT_W'(DEG_THRESH);
    localparam logic [CNT_W-1:0] FLT_T = CNT_W'(FLT_THRESH);

    if (NUM_CH < 1 || DEG_THRESH >= FLT_THRESH || FLT_THRESH > (2**CNT_W) - 1
        || DECAY_PERIOD < 1) begin : g_bad_param
        $error("pipeline_fault_monitor: illegal parameter combination");
    end

    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] nxt;
    logic [NUM_CH-1:0]            dec;
    logic [NUM_CH-1:0]            sticky_q, sticky_d;
    logic                         clr_ack_q;
    logic                         clr_go;
    logic                         tick;
    logic                         fatal_evt, nf_deg, nf_flt;
    logic                         irq_q, irq_d;
    logic [CNT_W-1:0]             rd_q, rd_d;
    fm_state_t                    state_q, state_d, base_st;

    // A request is only taken while no ack is showing, so one clear per two cycles.
    assign clr_go = clr_req & ~clr_ack_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign dec[gi] = tick & ~FATAL_MASK[gi] & ~err_in[gi];

        fm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (err_in[gi]),
            .dec_i (dec[gi]),
            .clr_i (clr_go),
            .cnt_o (cnt[gi]),
            .nxt_o (nxt[gi])
        );
    end

`ifdef FAULT_DECAY_EN
    localparam int            DW         = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DW-1:0] DECAY_LOAD = DW'(DECAY_PERIOD - 1);

    logic [DW-1:0] decay_q, decay_d;

    assign tick = (decay_q == '0);

    always_comb begin
        decay_d = tick ? DECAY_LOAD : decay_q - DW'(1);
        if (clr_go) decay_d = DECAY_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) decay_q <= DECAY_LOAD;
        else     decay_q <= decay_d;
    end
`else
    assign tick = 1'b0;
`endif

    assign fatal_evt = |(err_in & FATAL_MASK);

    // Thresholds look at the post-update counts so escalation lands one cycle after the event.
    always_comb begin
        nf_deg = 1'b0;
        nf_flt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!FATAL_MASK[i]) begin
                if (nxt[i] >= DEG_T) nf_deg = 1'b1;
                if (nxt[i] >= FLT_T) nf_flt = 1'b1;
            end
        end
    end

    always_comb begin
        base_st = clr_go ? FM_OK : state_q;
        state_d = base_st;
        if (fatal_evt || nf_flt) begin
            state_d = FM_FAULT;
        end else if (base_st == FM_OK && nf_deg) begin
            state_d = FM_DEGRADED;
        end else if (base_st == FM_DEGRADED && tick && !nf_deg) begin
            state_d = FM_OK;
        end
        irq_d = ((state_d == FM_FAULT) && (base_st != FM_FAULT)) ||
                ((state_d == FM_DEGRADED) && (base_st == FM_OK));
    end

    assign sticky_d = (clr_go ? '0 : sticky_q) | err_in;

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == RD_W'(i)) rd_d = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FM_OK;
            sticky_q  <= '0;
            clr_ack_q <= 1'b0;
            irq_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            sticky_q  <= sticky_d;
            clr_ack_q <= clr_go;
            irq_q     <= irq_d;
            rd_q      <= rd_d;
        end
    end

    assign clr_ack   = clr_ack_q;
    assign irq       = irq_q;
    assign rd_count  = rd_q;
    assign sticky    = sticky_q;
    assign state     = state_q;
    assign stall_req = (state_q == FM_FAULT);

endmodule

// File: tb/tb_pipeline_fault_monitor.sv
// Directed bench for pipeline_fault_monitor; decay steps run only when FAULT_DECAY_EN is defined.
module tb_pipeline_fault_monitor;
    import fm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] err_in;
    logic       clr_req;
    logic       clr_ack;
    logic [2:0] rd_ch;
    logic [7:0] rd_count;
    logic [5:0] sticky;
    logic [1:0] state;
    logic       stall_req;
    logic       irq;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    pipeline_fault_monitor #(
        .NUM_CH       (6),
        .CNT_W        (8),
        .FATAL_MASK   (6'b101010),
        .DEG_THRESH   (4),
        .FLT_THRESH   (16),
        .DECAY_PERIOD (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .err_in    (err_in),
        .clr_req   (clr_req),
        .clr_ack   (clr_ack),
        .rd_ch     (rd_ch),
        .rd_count  (rd_count),
        .sticky    (sticky),
        .state     (state),
        .stall_req (stall_req),
        .irq       (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"},  32'(state),     32'(FM_OK));
        chk({tag, "_sticky"}, 32'(sticky),    32'd0);
        chk({tag, "_rd"},     32'(rd_count),  32'd0);
        chk({tag, "_irq"},    32'(irq),       32'd0);
        chk({tag, "_stall"},  32'(stall_req), 32'd0);
        chk({tag, "_ack"},    32'(clr_ack),   32'd0);
    endtask

    task automatic rd(input int ch, input logic [31:0] exp, input string tag);
        rd_ch = 3'(ch);
        step();
        chk(tag, 32'(rd_count), exp);
    endtask

    initial begin
        rst     = 1'b1;
        err_in  = '0;
        clr_req = 1'b0;
        rd_ch   = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle("rst");
        repeat (10) step();
        chk_idle("idle10");

        // Four single-cycle non-fatal pulses on ch0, started right after a clear.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            err_in = 6'b000001;
            step();
            err_in = '0;
            if (k < 3) begin
                chk("deg_early_state", 32'(state), 32'(FM_OK));
                step();
            end
        end
        chk("deg_state",  32'(state),  32'(FM_DEGRADED));
        chk("deg_irq",    32'(irq),    32'd1);
        chk("deg_sticky", 32'(sticky), 32'h01);
        step();
        chk("deg_irq_end", 32'(irq),      32'd0);
        chk("deg_hold",    32'(state),    32'(FM_DEGRADED));
        chk("deg_cnt0",    32'(rd_count), 32'd4);

        // Fatal pulse on ch1 from OK.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("clr1_state", 32'(state), 32'(FM_OK));
        chk("clr1_ack",   32'(clr_ack), 32'd1);
        err_in = 6'b000010;
        step();
        err_in = '0;
        chk("flt_state", 32'(state),     32'(FM_FAULT));
        chk("flt_stall", 32'(stall_req), 32'd1);
        chk("flt_irq",   32'(irq),       32'd1);
        step();
        chk("flt_irq_end", 32'(irq), 32'd0);
        repeat (300) step();
        chk("flt_hold",  32'(state),     32'(FM_FAULT));
        chk("flt_stall2", 32'(stall_req), 32'd1);
        rd(1, 32'd1, "flt_cnt1");

        // ch0 held for 300 cycles saturates at 255.
        err_in = 6'b000001;
        repeat (300) step();
        err_in = '0;
        rd(0, 32'd255, "sat_cnt0");
        chk("sat_state",  32'(state),  32'(FM_FAULT));
        chk("sat_sticky", 32'(sticky), 32'h03);
        chk("sat_irq",    32'(irq),    32'd0);

        // Clear on the same edge as a ch2 event.
        clr_req = 1'b1;
        err_in  = 6'b000100;
        step();
        clr_req = 1'b0;
        err_in  = '0;
        chk("clrevt_ack",    32'(clr_ack), 32'd1);
        chk("clrevt_sticky", 32'(sticky),  32'h04);
        chk("clrevt_state",  32'(state),   32'(FM_OK));
        chk("clrevt_stall",  32'(stall_req), 32'd0);
        rd(2, 32'd1, "clrevt_cnt2");
        rd(0, 32'd0, "clrevt_cnt0");
        rd(1, 32'd0, "clrevt_cnt1");

        // Clear on the same edge as a fatal event stays in FAULT with irq.
        clr_req = 1'b1;
        err_in  = 6'b000010;
        step();
        err_in = '0;
        chk("clrfat_state",  32'(state),   32'(FM_FAULT));
        chk("clrfat_irq",    32'(irq),     32'd1);
        chk("clrfat_ack",    32'(clr_ack), 32'd1);
        chk("clrfat_sticky", 32'(sticky),  32'h02);

        // Request still held: ignored while ack shows, accepted on the next edge.
        step();
        chk("clrhold_ack",   32'(clr_ack), 32'd0);
        chk("clrhold_state", 32'(state),   32'(FM_FAULT));
        step();
        clr_req = 1'b0;
        chk("clrhold_ack2",   32'(clr_ack), 32'd1);
        chk("clrhold_state2", 32'(state),   32'(FM_OK));

        // Non-fatal ch0 held: DEGRADED at count 4, FAULT at count 16.
        err_in = 6'b000001;
        repeat (4) step();
        chk("nf_deg_state", 32'(state), 32'(FM_DEGRADED));
        chk("nf_deg_irq",   32'(irq),   32'd1);
        repeat (11) step();
        chk("nf_15_state", 32'(state), 32'(FM_DEGRADED));
        chk("nf_15_irq",   32'(irq),   32'd0);
        step();
        err_in = '0;
        chk("nf_flt_state", 32'(state),     32'(FM_FAULT));
        chk("nf_flt_irq",   32'(irq),       32'd1);
        chk("nf_flt_stall", 32'(stall_req), 32'd1);
        rd(6, 32'd0, "rd_oob6");
        rd(0, 32'd16, "nf_flt_cnt0");

        // Reset on the edge a clear would be accepted drops the ack.
        clr_req = 1'b1;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        chk("rstclr_ack",   32'(clr_ack),   32'd0);
        chk("rstclr_state", 32'(state),     32'(FM_OK));
        chk("rstclr_stall", 32'(stall_req), 32'd0);
        chk("rstclr_rd",    32'(rd_count),  32'd0);
        step();
        clr_req = 1'b0;
        chk("rereq_ack", 32'(clr_ack), 32'd1);

`ifdef FAULT_DECAY_EN
        // Decay: cnt0=5 then 16 idle cycles -> two ticks -> cnt0=3, back to OK.
        err_in = 6'b000001;
        repeat (5) step();
        err_in = '0;
        chk("dec_deg_state", 32'(state), 32'(FM_DEGRADED));
        repeat (16) step();
        chk("dec_ok_state", 32'(state), 32'(FM_OK));
        chk("dec_irq",      32'(irq),   32'd0);
        chk("dec_sticky",   32'(sticky), 32'h01);
        rd(0, 32'd3, "dec_cnt0");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
